exp_pulse_source: RTL and testbench



---
 rtl/exp_pulse_source_pkg.sv | 23 ++
 rtl/exp_pulse_source_lfsr.sv | 25 ++
 rtl/exp_pulse_source.sv | 172 +++++++++++++++++
 tb/tb_exp_pulse_source.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exp_pulse_source_pkg.sv
// package_settings_v_6: shared constants for the synthetic pulse source.
// Holds the sample width, the FSM state type, the LFSR seed/taps and the
// amplitude-register ceiling used by exp_pulse_source and exp_pulse_lfsr.
package package_settings_v_6;

  localparam int SIZE_FILTER_DATA = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RISE  = 2'd1,
    DECAY = 2'd2
  } pulse_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as a mask over bits [15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Largest amplitude value whose integer part still fits a positive sample
  function automatic logic [63:0] vmax_of(input int frac);
    vmax_of = ((64'd1 << (SIZE_FILTER_DATA - 1)) << frac) - 64'd1;
  endfunction

endpackage

// File: rtl/exp_pulse_source_lfsr.sv
// exp_pulse_lfsr: 16-bit Fibonacci LFSR dither source for exp_pulse_source.
// Only instantiated when EXP_PULSE_NOISE_EN is defined.
module exp_pulse_lfsr
  import package_settings_v_6::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  output logic signed [2:0] noise
);

  logic [15:0] lfsr;

  // Shift one step per sample tick, feedback is the XOR of the tapped bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else if (advance) begin
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  assign noise = $signed(lfsr[2:0]);

endmodule

// File: rtl/exp_pulse_source.sv
// exp_pulse_source: synthetic detector pulse generator feeding the shaping
// filter. Linear rise of 2**RISE_SHIFT samples, then exponential decay with
// factor (1 - 2**-DECAY_SHIFT); triggers during decay pile up on the tail.
// Build macro EXP_PULSE_NOISE_EN adds -4..+3 LSB of LFSR dither per sample.
module exp_pulse_source
  import package_settings_v_6::*;
#(
  parameter int SAMPLE_DIV  = 1,
  parameter int RISE_SHIFT  = 2,
  parameter int DECAY_SHIFT = 5,
  parameter int FRAC        = 8,
  parameter int BASELINE    = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               trig_valid,
  input  logic [SIZE_FILTER_DATA-2:0]        trig_amp,
  output logic                               trig_ready,
  output logic signed [SIZE_FILTER_DATA-1:0] output_data,
  output logic                               sample_tick,
  output logic                               pulse_active,
  output logic [15:0]                        pulse_cnt
);

  localparam int VW = SIZE_FILTER_DATA + FRAC + 1;
  localparam int SW = VW + 16;
  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int RW = RISE_SHIFT + 1;

  localparam logic [VW-1:0] VMAX      = VW'(vmax_of(FRAC));
  localparam logic [VW-1:0] VFLOOR    = VW'(1) << FRAC;
  localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
  localparam logic [RW-1:0] RISE_LAST = RW'((1 << RISE_SHIFT) - 1);

  localparam logic signed [SW-1:0] OUT_MAX  =
    signed'(SW'((64'd1 << (SIZE_FILTER_DATA - 1)) - 64'd1));
  localparam logic signed [SW-1:0] OUT_MIN  = ~OUT_MAX;
  localparam logic signed [SW-1:0] BASE_EXT = SW'(BASELINE);

  pulse_state_t state, state_next;

  logic [DW-1:0]    div_cnt;
  logic             tick;
  logic             accept;
  logic [RW-1:0]    rise_cnt, rise_cnt_next;
  logic [VW-1:0]    v, v_calc, v_update, step, step_new;
  logic [VW:0]      v_sum;
  logic signed [SW-1:0] out_sum, noise_ext;

  function automatic logic signed [SIZE_FILTER_DATA-1:0] sat_signed(
    input logic signed [SW-1:0] x
  );
    logic signed [SIZE_FILTER_DATA-1:0] r;
    if (x > OUT_MAX) begin
      r = OUT_MAX[SIZE_FILTER_DATA-1:0];
    end else if (x < OUT_MIN) begin
      r = OUT_MIN[SIZE_FILTER_DATA-1:0];
    end else begin
      r = x[SIZE_FILTER_DATA-1:0];
    end
    return r;
  endfunction

  assign tick         = (div_cnt == DIV_LAST);
  assign sample_tick  = tick && !reset;
  assign trig_ready   = (state != RISE);
  assign pulse_active = (state != IDLE);
  assign accept       = trig_valid && trig_ready;
  assign step_new     = (VW'(trig_amp) << FRAC) >> RISE_SHIFT;

`ifdef EXP_PULSE_NOISE_EN
  logic signed [2:0] noise;

  exp_pulse_lfsr u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (tick),
    .noise   (noise)
  );

  assign noise_ext = SW'(noise);
`else
  assign noise_ext = '0;
`endif

  // Amplitude arithmetic for the next sample: decay, optional rise step, clamp
  always_comb begin
    v_sum   = {1'b0, v} - {1'b0, (v >> DECAY_SHIFT)}
              + ((state == RISE) ? {1'b0, step} : '0);
    v_calc  = (v_sum > {1'b0, VMAX}) ? VMAX : v_sum[VW-1:0];
    out_sum = BASE_EXT + signed'({{(SW - VW){1'b0}}, (v_calc >> FRAC)}) + noise_ext;
    v_update = v_calc;
    if (state == IDLE) begin
      v_update = '0;
    end else if ((state == DECAY) && (v_calc < VFLOOR)) begin
      v_update = '0;
    end
  end

  // Next-state logic; a trigger wins over the tick-driven transitions
  always_comb begin
    state_next    = state;
    rise_cnt_next = rise_cnt;
    if (accept) begin
      state_next    = RISE;
      rise_cnt_next = '0;
    end else if (tick) begin
      case (state)
        RISE: begin
          if (rise_cnt == RISE_LAST) begin
            state_next    = DECAY;
            rise_cnt_next = '0;
          end else begin
            rise_cnt_next = rise_cnt + RW'(1);
          end
        end
        DECAY: begin
          if (v_calc < VFLOOR) begin
            state_next = IDLE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State register and rise counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rise_cnt <= '0;
    end else begin
      state    <= state_next;
      rise_cnt <= rise_cnt_next;
    end
  end

  // Sample-rate divider, wraps on the tick clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Capture the rise step and count triggers on every accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step      <= '0;
      pulse_cnt <= '0;
    end else if (accept) begin
      step      <= step_new;
      pulse_cnt <= pulse_cnt + 16'd1;
    end
  end

  // Amplitude register and output sample update together on each tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v           <= '0;
      output_data <= sat_signed(BASE_EXT);
    end else if (tick) begin
      v           <= v_update;
      output_data <= sat_signed(out_sum);
    end
  end

endmodule

// File: tb/tb_exp_pulse_source.sv
// tb_exp_pulse_source: self-checking bench for exp_pulse_source (default
// build, EXP_PULSE_NOISE_EN undefined). A second instance runs with
// SAMPLE_DIV = 4 to exercise the sample divider.
module tb_exp_pulse_source;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic               trig_valid = 1'b0;
  logic [14:0]        trig_amp = '0;
  logic               trig_ready;
  logic signed [15:0] output_data;
  logic               sample_tick;
  logic               pulse_active;
  logic [15:0]        pulse_cnt;

  logic               t4_valid = 1'b0;
  logic [14:0]        t4_amp = '0;
  logic               t4_ready;
  logic signed [15:0] t4_data;
  logic               t4_tick;
  logic               t4_active;
  logic [15:0]        t4_cnt;

  int total = 0;
  int bad = 0;

  // Reference model: amplitude in units of 1/256 LSB, rise tracked as ticks remaining
  localparam longint VMAX = 64'd8388607;
  longint             m_v = 0;
  longint             m_step = 0;
  int                 m_rise_left = 0;
  bit                 m_active = 1'b0;
  logic [15:0]        m_cnt = '0;
  logic signed [15:0] m_out = '0;

  exp_pulse_source dut (
    .clk          (clk),
    .reset        (reset),
    .trig_valid   (trig_valid),
    .trig_amp     (trig_amp),
    .trig_ready   (trig_ready),
    .output_data  (output_data),
    .sample_tick  (sample_tick),
    .pulse_active (pulse_active),
    .pulse_cnt    (pulse_cnt)
  );

  exp_pulse_source #(.SAMPLE_DIV(4)) dut4 (
    .clk          (clk),
    .reset        (reset),
    .trig_valid   (t4_valid),
    .trig_amp     (t4_amp),
    .trig_ready   (t4_ready),
    .output_data  (t4_data),
    .sample_tick  (t4_tick),
    .pulse_active (t4_active),
    .pulse_cnt    (t4_cnt)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic signed [15:0] sat16(input longint x);
    if (x > 32767) return 16'sh7FFF;
    if (x < -32768) return 16'sh8000;
    return 16'(x);
  endfunction

  function automatic void model_reset();
    m_v = 0;
    m_step = 0;
    m_rise_left = 0;
    m_active = 1'b0;
    m_cnt = '0;
    m_out = sat16(0);
  endfunction

  // Drive one clock of stimulus on the main DUT, advance the model, sample 1ns after the edge
  task automatic applyStimulus(input bit valid, input int amp);
    bit     acc;
    longint nv;
    trig_valid = valid;
    trig_amp   = 15'(amp);
    acc = valid && (m_rise_left == 0);
    if (m_active) begin
      nv = m_v - m_v / 32 + ((m_rise_left > 0) ? m_step : 0);
      if (nv > VMAX) nv = VMAX;
      m_out = sat16(nv / 256);
      if (m_rise_left > 0) begin
        m_rise_left--;
        m_v = nv;
      end else if (nv < 256) begin
        m_v = 0;
        m_active = 1'b0;
      end else begin
        m_v = nv;
      end
    end else begin
      m_v = 0;
      m_out = sat16(0);
    end
    if (acc) begin
      m_step = longint'(amp) * 256 / 4;
      m_rise_left = 4;
      m_active = 1'b1;
      m_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    trig_valid = 1'b0;
    trig_amp = '0;
    t4_valid = 1'b0;
    t4_amp = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (output_data !== 16'sd0) begin
      bad++; $display("[TB] FAIL rst_out got=%0d exp=0", output_data);
    end
    total++;
    if (sample_tick !== 1'b0 || t4_tick !== 1'b0) begin
      bad++; $display("[TB] FAIL rst_tick got=%b/%b exp=0/0", sample_tick, t4_tick);
    end
    total++;
    if (pulse_active !== 1'b0 || trig_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL rst_flags active=%b ready=%b exp active=0 ready=1", pulse_active, trig_ready);
    end
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 100; k++) begin
      applyStimulus(1'b0, 0);
      total++;
      if (output_data !== 16'sd0 || trig_ready !== 1'b1 || pulse_cnt !== 16'd0) begin
        bad++;
        $display("[TB] FAIL idle_hold k=%0d out=%0d ready=%b cnt=%0d exp out=0 ready=1 cnt=0",
                 k, output_data, trig_ready, pulse_cnt);
      end
    end
  endtask

  task automatic test_single_pulse();
    int ready_low;
    int budget;
    bit in_decay;
    logic signed [15:0] prev;
    ready_low = 0;
    applyStimulus(1'b1, 1000);
    total++;
    if (trig_ready !== 1'b0 || pulse_cnt !== 16'd1) begin
      bad++; $display("[TB] FAIL sp_accept ready=%b cnt=%0d exp ready=0 cnt=1", trig_ready, pulse_cnt);
    end
    if (trig_ready === 1'b0) ready_low++;
    applyStimulus(1'b0, 0);
    total++;
    if (output_data !== 16'sd250) begin
      bad++; $display("[TB] FAIL sp_rise1 got=%0d exp=250", output_data);
    end
    if (trig_ready === 1'b0) ready_low++;
    applyStimulus(1'b0, 0);
    total++;
    if (output_data !== 16'sd492) begin
      bad++; $display("[TB] FAIL sp_rise2 got=%0d exp=492", output_data);
    end
    if (trig_ready === 1'b0) ready_low++;
    prev = output_data;
    in_decay = 1'b0;
    budget = 0;
    while (pulse_active === 1'b1 && budget < 1000) begin
      applyStimulus(1'b0, 0);
      budget++;
      if (trig_ready === 1'b0) ready_low++;
      total++;
      if (output_data !== m_out) begin
        bad++; $display("[TB] FAIL sp_model step=%0d got=%0d exp=%0d", budget, output_data, m_out);
      end
      if (trig_ready === 1'b1 && in_decay) begin
        total++;
        if (output_data > prev) begin
          bad++; $display("[TB] FAIL sp_monotonic got=%0d prev=%0d", output_data, prev);
        end
      end
      if (trig_ready === 1'b1) in_decay = 1'b1;
      prev = output_data;
    end
    total++;
    if (pulse_active !== 1'b0 || m_active !== 1'b0) begin
      bad++; $display("[TB] FAIL sp_end_idle active=%b model=%b exp both 0", pulse_active, m_active);
    end
    total++;
    if (ready_low !== 4) begin
      bad++; $display("[TB] FAIL sp_ready_low got=%0d exp=4", ready_low);
    end
    total++;
    if (output_data !== 16'sd0) begin
      bad++; $display("[TB] FAIL sp_final_out got=%0d exp=0", output_data);
    end
  endtask

  task automatic test_busy();
    int first_acc;
    int second_acc;
    int budget;
    logic [15:0] prev_cnt;
    do_reset();
    first_acc = -1;
    second_acc = -1;
    prev_cnt = pulse_cnt;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b1, 500);
      if (pulse_cnt !== prev_cnt) begin
        if (first_acc < 0) first_acc = k;
        else if (second_acc < 0) second_acc = k;
      end
      prev_cnt = pulse_cnt;
      total++;
      if (pulse_cnt !== m_cnt || trig_ready !== 1'(m_rise_left == 0)) begin
        bad++;
        $display("[TB] FAIL busy_hs k=%0d cnt=%0d ready=%b exp cnt=%0d ready=%b",
                 k, pulse_cnt, trig_ready, m_cnt, (m_rise_left == 0));
      end
    end
    total++;
    if (first_acc !== 0 || second_acc !== 5) begin
      bad++; $display("[TB] FAIL busy_accept_clk got=%0d,%0d exp=0,5", first_acc, second_acc);
    end
    total++;
    if (pulse_cnt !== 16'd3) begin
      bad++; $display("[TB] FAIL busy_count got=%0d exp=3", pulse_cnt);
    end
    budget = 0;
    while (m_active && budget < 2000) begin
      applyStimulus(1'b0, 0);
      budget++;
    end
    total++;
    if (pulse_active !== 1'b0 || output_data !== m_out) begin
      bad++; $display("[TB] FAIL busy_drain active=%b out=%0d exp active=0 out=%0d", pulse_active, output_data, m_out);
    end
  endtask

  task automatic test_pile_up();
    int budget;
    int max_out;
    bit saw_neg;
    do_reset();
    max_out = 0;
    saw_neg = 1'b0;
    applyStimulus(1'b1, 20000);
    for (int k = 1; k < 10; k++) applyStimulus(1'b0, 0);
    applyStimulus(1'b1, 20000);
    budget = 0;
    while ((m_active || pulse_active === 1'b1) && budget < 3000) begin
      applyStimulus(1'b0, 0);
      budget++;
      if (int'(output_data) > max_out) max_out = int'(output_data);
      if (output_data < 0) saw_neg = 1'b1;
      total++;
      if (output_data !== m_out) begin
        bad++; $display("[TB] FAIL pile_model step=%0d got=%0d exp=%0d", budget, output_data, m_out);
      end
    end
    total++;
    if (max_out !== 32767) begin
      bad++; $display("[TB] FAIL pile_clamp max=%0d exp=32767", max_out);
    end
    total++;
    if (saw_neg) begin
      bad++; $display("[TB] FAIL pile_wrap negative sample seen exp none");
    end
    total++;
    if (pulse_cnt !== 16'd2 || pulse_active !== 1'b0) begin
      bad++; $display("[TB] FAIL pile_end cnt=%0d active=%b exp cnt=2 active=0", pulse_cnt, pulse_active);
    end
  endtask

  task automatic test_random();
    bit v;
    int a;
    do_reset();
    for (int k = 0; k < 800; k++) begin
      v = ($urandom_range(0, 11) == 0);
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 32767));
      applyStimulus(v, a);
      total++;
      if (output_data !== m_out) begin
        bad++; $display("[TB] FAIL rnd_out k=%0d got=%0d exp=%0d", k, output_data, m_out);
      end
      total++;
      if (trig_ready !== 1'(m_rise_left == 0)) begin
        bad++; $display("[TB] FAIL rnd_ready k=%0d got=%b exp=%b", k, trig_ready, (m_rise_left == 0));
      end
      total++;
      if (pulse_active !== m_active) begin
        bad++; $display("[TB] FAIL rnd_active k=%0d got=%b exp=%b", k, pulse_active, m_active);
      end
      total++;
      if (pulse_cnt !== m_cnt) begin
        bad++; $display("[TB] FAIL rnd_cnt k=%0d got=%0d exp=%0d", k, pulse_cnt, m_cnt);
      end
    end
  endtask

  task automatic test_div4();
    bit prev_tick;
    logic signed [15:0] prev_data;
    int tick_outs[4];
    int n_ticks;
    do_reset();
    n_ticks = 0;
    total++;
    if (t4_tick !== 1'b0) begin
      bad++; $display("[TB] FAIL div4_first_tick got=%b exp=0", t4_tick);
    end
    t4_amp = 15'd1000;
    for (int k = 1; k <= 16; k++) begin
      t4_valid = (k == 1);
      prev_tick = t4_tick;
      prev_data = t4_data;
      applyStimulus(1'b0, 0);
      total++;
      if (t4_tick !== 1'((k % 4) == 3)) begin
        bad++; $display("[TB] FAIL div4_period k=%0d got=%b exp=%b", k, t4_tick, ((k % 4) == 3));
      end
      total++;
      if (!prev_tick && t4_data !== prev_data) begin
        bad++; $display("[TB] FAIL div4_hold k=%0d got=%0d exp=%0d", k, t4_data, prev_data);
      end
      if (prev_tick && n_ticks < 4) begin
        tick_outs[n_ticks] = int'(t4_data);
        n_ticks++;
      end
    end
    t4_valid = 1'b0;
    total++;
    if (n_ticks !== 4 || tick_outs[0] !== 250 || tick_outs[1] !== 492 ||
        tick_outs[2] !== 726 || tick_outs[3] !== 954) begin
      bad++;
      $display("[TB] FAIL div4_rise n=%0d got=%0d,%0d,%0d,%0d exp=250,492,726,954",
               n_ticks, tick_outs[0], tick_outs[1], tick_outs[2], tick_outs[3]);
    end
    total++;
    if (t4_cnt !== 16'd1) begin
      bad++; $display("[TB] FAIL div4_cnt got=%0d exp=1", t4_cnt);
    end
  endtask

  task automatic test_reset_mid_decay();
    do_reset();
    applyStimulus(1'b1, 5000);
    for (int k = 0; k < 15; k++) applyStimulus(1'b0, 0);
    total++;
    if (pulse_active !== 1'b1 || output_data !== m_out || output_data == 0) begin
      bad++; $display("[TB] FAIL mid_pre active=%b out=%0d exp active=1 out=%0d", pulse_active, output_data, m_out);
    end
    #3;
    reset = 1'b1;
    #1;
    total++;
    if (output_data !== 16'sd0) begin
      bad++; $display("[TB] FAIL mid_async_out got=%0d exp=0", output_data);
    end
    total++;
    if (pulse_active !== 1'b0 || trig_ready !== 1'b1 || pulse_cnt !== 16'd0 || sample_tick !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_async_flags active=%b ready=%b cnt=%0d tick=%b exp 0/1/0/0",
               pulse_active, trig_ready, pulse_cnt, sample_tick);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    applyStimulus(1'b0, 0);
    total++;
    if (output_data !== 16'sd0 || pulse_active !== 1'b0) begin
      bad++; $display("[TB] FAIL mid_after out=%0d active=%b exp out=0 active=0", output_data, pulse_active);
    end
  endtask

  initial begin
    $display("[TB] starting exp_pulse_source bench");
    test_reset();
    test_single_pulse();
    test_busy();
    test_pile_up();
    test_random();
    test_div4();
    test_reset_mid_decay();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
